// File: rtl/mbist_pkg.sv
// Shared March C- encoding and FSM state type for the MBIST controller.
// Element tables hold one bit per element index; bits 6..7 are padding.
package mbist_pkg;

  typedef enum logic [2:0] {
    E0 = 3'd0,
    E1 = 3'd1,
    E2 = 3'd2,
    E3 = 3'd3,
    E4 = 3'd4,
    E5 = 3'd5
  } elem_e;

  typedef enum logic [2:0] {
    S_IDLE,
    S_PREP,
    S_RUN,
    S_DRAIN,
    S_DONE
  } state_e;

  localparam logic [7:0] ELEM_DOWN    = 8'b0001_1000;
  localparam logic [7:0] ELEM_TWO_OPS = 8'b0001_1110;
  localparam logic [7:0] OP0_WRITE    = 8'b0000_0001;
  localparam logic [7:0] OP1_WRITE    = 8'b0001_1110;
  localparam logic [7:0] OP0_ONE      = 8'b0001_0100;
  localparam logic [7:0] OP1_ONE      = 8'b0000_1010;

  function automatic logic elem_down(input logic [2:0] e);
    return ELEM_DOWN[e];
  endfunction

  function automatic logic elem_two_ops(input logic [2:0] e);
    return ELEM_TWO_OPS[e];
  endfunction

  function automatic logic op_write(input logic [2:0] e, input logic idx);
    return idx ? OP1_WRITE[e] : OP0_WRITE[e];
  endfunction

  // Data polarity of an op: written value for writes, expected value for reads.
  function automatic logic op_one(input logic [2:0] e, input logic idx);
    return idx ? OP1_ONE[e] : OP0_ONE[e];
  endfunction

endpackage

// File: rtl/mbist_cmp_pipe.sv
// Two-stage expected-data pipeline aligned to the memory read latency,
// with saturating mismatch count and first-fail capture.
module mbist_cmp_pipe
  import mbist_pkg::*;
#(
  parameter int DATA_WIDTH = 8,
  parameter int ADDR_WIDTH = 4,
  parameter int CNT_WIDTH  = 8
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  clr,
  input  logic                  issue_rd,
  input  logic [DATA_WIDTH-1:0] issue_exp,
  input  logic [ADDR_WIDTH-1:0] issue_addr,
  input  logic [2:0]            issue_elem,
  input  logic [DATA_WIDTH-1:0] rdata,
  output logic [CNT_WIDTH-1:0]  fail_cnt,
  output logic [ADDR_WIDTH-1:0] fail_addr,
  output logic [2:0]            fail_elem
);

  logic                  s1_vld, s2_vld;
  logic [DATA_WIDTH-1:0] s1_exp, s2_exp;
  logic [ADDR_WIDTH-1:0] s1_addr, s2_addr;
  logic [2:0]            s1_elem, s2_elem;

  always_ff @(posedge clk) begin
    if (rst || clr) begin
      s1_vld    <= 1'b0;
      s2_vld    <= 1'b0;
      s1_exp    <= '0;
      s2_exp    <= '0;
      s1_addr   <= '0;
      s2_addr   <= '0;
      s1_elem   <= '0;
      s2_elem   <= '0;
      fail_cnt  <= '0;
      fail_addr <= '0;
      fail_elem <= '0;
    end else begin
      s1_vld  <= issue_rd;
      s1_exp  <= issue_exp;
      s1_addr <= issue_addr;
      s1_elem <= issue_elem;
      s2_vld  <= s1_vld;
      s2_exp  <= s1_exp;
      s2_addr <= s1_addr;
      s2_elem <= s1_elem;
      if (s2_vld && (rdata != s2_exp)) begin
        if (fail_cnt != '1) fail_cnt <= fail_cnt + CNT_WIDTH'(1);
        // A zero count means this is the first mismatch of the test.
        if (fail_cnt == '0) begin
          fail_addr <= s2_addr;
          fail_elem <= s2_elem;
        end
      end
    end
  end

endmodule

// File: rtl/mbist_march_ctrl.sv
// March C- MBIST controller: sequences ops into the memory under test and
// reports pass/fail with first-fail diagnostics.
// state   | meaning
// S_IDLE  | waiting for start
// S_PREP  | one cycle, preloads write data for op 0
// S_RUN   | one op per cycle, all six elements
// S_DRAIN | two cycles for in-flight reads
// S_DONE  | one-cycle done pulse, pass valid
module mbist_march_ctrl
  import mbist_pkg::*;
#(
  parameter int DATA_WIDTH = 8,
  parameter int ADDR_WIDTH = 4,
  parameter int LAST_ADDR  = 15,
  parameter int CNT_WIDTH  = 8
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  output logic                  busy,
  output logic                  done,
  output logic                  pass,
  output logic [CNT_WIDTH-1:0]  fail_cnt,
  output logic [ADDR_WIDTH-1:0] fail_addr,
  output logic [2:0]            fail_elem,
  output logic                  mem_write_read,
  output logic [ADDR_WIDTH-1:0] mem_address,
  output logic [DATA_WIDTH-1:0] mem_wdata,
  input  logic [DATA_WIDTH-1:0] mem_rdata
);

  localparam logic [ADDR_WIDTH-1:0] ADDR_LAST = ADDR_WIDTH'(LAST_ADDR);

  state_e                state, state_nxt;
  elem_e                 elem;
  logic [ADDR_WIDTH-1:0] addr;
  logic                  op_idx, drain_cnt, pass_q;
  logic                  cur_write, last_op, last_addr, elem_end, run_end, accept;
  logic [2:0]            nx_elem;
  logic                  nx_idx, issue_rd;
  logic [DATA_WIDTH-1:0] issue_exp;

  always_comb begin
    cur_write = op_write(3'(elem), op_idx);
    last_op   = !elem_two_ops(3'(elem)) || op_idx;
    last_addr = elem_down(3'(elem)) ? (addr == '0) : (addr == ADDR_LAST);
    elem_end  = last_op && last_addr;
    run_end   = elem_end && (elem == E5);
    nx_elem   = elem_end ? 3'(elem) + 3'd1 : 3'(elem);
    nx_idx    = !last_op;
    accept    = (state == S_IDLE) && start;
    issue_rd  = (state == S_RUN) && !cur_write;
    issue_exp = {DATA_WIDTH{op_one(3'(elem), op_idx)}};
  end

  always_ff @(posedge clk) begin
    if (rst) state <= S_IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE:  if (start) state_nxt = S_PREP;
      S_PREP:  state_nxt = S_RUN;
      S_RUN:   if (run_end) state_nxt = S_DRAIN;
      S_DRAIN: if (drain_cnt == 1'b0) state_nxt = S_DONE;
      S_DONE:  state_nxt = S_IDLE;
      default: state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      elem      <= E0;
      addr      <= '0;
      op_idx    <= 1'b0;
      drain_cnt <= 1'b0;
      pass_q    <= 1'b0;
    end else begin
      case (state)
        S_IDLE: if (start) begin
          elem   <= E0;
          addr   <= '0;
          op_idx <= 1'b0;
          pass_q <= 1'b0;
        end
        S_RUN: begin
          op_idx <= nx_idx;
          if (last_op && !last_addr) begin
            addr <= elem_down(3'(elem)) ? addr - ADDR_WIDTH'(1) : addr + ADDR_WIDTH'(1);
          end else if (elem_end && !run_end) begin
            elem <= elem_e'(nx_elem);
            addr <= elem_down(nx_elem) ? ADDR_LAST : '0;
          end else if (run_end) begin
            elem      <= E0;
            addr      <= '0;
            drain_cnt <= 1'b1;
          end
        end
        S_DRAIN: drain_cnt <= 1'b0;
        S_DONE:  pass_q    <= (fail_cnt == '0);
        default: ;
      endcase
    end
  end

  // Write data runs one op ahead of the strobe, so RUN shows the next op's data.
  always_comb begin
    busy           = 1'b0;
    done           = 1'b0;
    pass           = pass_q;
    mem_write_read = 1'b0;
    mem_address    = '0;
    mem_wdata      = '0;
    case (state)
      S_PREP: begin
        busy      = 1'b1;
        mem_wdata = {DATA_WIDTH{op_one(3'(elem), op_idx)}};
      end
      S_RUN: begin
        busy           = 1'b1;
        mem_write_read = cur_write;
        mem_address    = addr;
        mem_wdata      = {DATA_WIDTH{op_one(nx_elem, nx_idx)}};
      end
      S_DRAIN: busy = 1'b1;
      S_DONE: begin
        done = 1'b1;
        pass = (fail_cnt == '0);
      end
      default: ;
    endcase
  end

  mbist_cmp_pipe #(
    .DATA_WIDTH(DATA_WIDTH),
    .ADDR_WIDTH(ADDR_WIDTH),
    .CNT_WIDTH (CNT_WIDTH)
  ) u_cmp (
    .clk       (clk),
    .rst       (rst),
    .clr       (accept),
    .issue_rd  (issue_rd),
    .issue_exp (issue_exp),
    .issue_addr(addr),
    .issue_elem(3'(elem)),
    .rdata     (mem_rdata),
    .fail_cnt  (fail_cnt),
    .fail_addr (fail_addr),
    .fail_elem (fail_elem)
  );

endmodule

// File: tb/tb_mbist_march_ctrl.sv
// Directed bench for mbist_march_ctrl: fault-free, stuck-at and inverting
// memory models, op-trace timing, mid-test reset and held-start behaviour.
module tb_mbist_march_ctrl;

  logic       clk = 1'b0;
  logic       rst, start, start2;
  int         cyc = 0;
  int         checks = 0;
  int         errors = 0;
  int         mode = 0;

  logic       busy, done, pass, mem_write_read;
  logic [7:0] fail_cnt, mem_wdata, mem_rdata;
  logic [3:0] fail_addr, mem_address;
  logic [2:0] fail_elem;

  logic       busy2, done2, pass2, mem_write_read2;
  logic [3:0] fail_cnt2, fail_addr2, mem_address2;
  logic [2:0] fail_elem2;
  logic [7:0] mem_wdata2;
  logic [7:0] mem_rdata2 = 8'h5A;

  logic [7:0] mem [0:15];
  logic [7:0] wlat, rd1, rd2;

  logic       tr_we    [0:4095];
  logic [3:0] tr_addr  [0:4095];
  logic [7:0] tr_wd    [0:4095];
  logic       tr_busy  [0:4095];
  logic       tr_busy2 [0:4095];
  int         done_cnt = 0;
  int         done2_cnt = 0;
  int         last_done2 = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  mbist_march_ctrl #(.DATA_WIDTH(8), .ADDR_WIDTH(4), .LAST_ADDR(15), .CNT_WIDTH(8)) dut (
    .clk(clk), .rst(rst), .start(start), .busy(busy), .done(done), .pass(pass),
    .fail_cnt(fail_cnt), .fail_addr(fail_addr), .fail_elem(fail_elem),
    .mem_write_read(mem_write_read), .mem_address(mem_address),
    .mem_wdata(mem_wdata), .mem_rdata(mem_rdata)
  );

  mbist_march_ctrl #(.DATA_WIDTH(8), .ADDR_WIDTH(4), .LAST_ADDR(15), .CNT_WIDTH(4)) dut2 (
    .clk(clk), .rst(rst), .start(start2), .busy(busy2), .done(done2), .pass(pass2),
    .fail_cnt(fail_cnt2), .fail_addr(fail_addr2), .fail_elem(fail_elem2),
    .mem_write_read(mem_write_read2), .mem_address(mem_address2),
    .mem_wdata(mem_wdata2), .mem_rdata(mem_rdata2)
  );

  // mode 1: address 5 bit 3 stuck at 0; mode 2: address 9 stores bit 1 inverted
  function automatic logic [7:0] faulty(input logic [3:0] a, input logic [7:0] d);
    logic [7:0] r;
    r = d;
    if (mode == 1 && a == 4'd5) r[3] = 1'b0;
    if (mode == 2 && a == 4'd9) r[1] = ~r[1];
    return r;
  endfunction

  // Memory: wdata latched the cycle before the strobe, 2-cycle read latency.
  assign mem_rdata = rd2;
  always @(posedge clk) begin
    wlat <= mem_wdata;
    rd1  <= mem[mem_address];
    rd2  <= rd1;
    if (mem_write_read) mem[mem_address] <= faulty(mem_address, wlat);
  end

  always @(negedge clk) begin
    if (cyc < 4096) begin
      tr_we[cyc]    <= mem_write_read;
      tr_addr[cyc]  <= mem_address;
      tr_wd[cyc]    <= mem_wdata;
      tr_busy[cyc]  <= busy;
      tr_busy2[cyc] <= busy2;
    end
    if (done) done_cnt <= done_cnt + 1;
    if (done2) begin
      done2_cnt  <= done2_cnt + 1;
      last_done2 <= cyc;
    end
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic run_test(output int s, output int dc);
    int n;
    @(negedge clk);
    start = 1'b1;
    s = cyc;
    @(negedge clk);
    start = 1'b0;
    n = 0;
    while (done !== 1'b1 && n < 400) begin
      @(negedge clk);
      n++;
    end
    dc = cyc;
  endtask

  initial begin
    int s, dc, d0, n, wr_cnt;
    logic [3:0] cap_cnt, cap_addr;
    logic [2:0] cap_elem;
    logic cap_pass, cap_done, cap_we;
    logic [3:0] cap_a;
    logic [7:0] cap_wd;
    rst = 1'b1;
    start = 1'b0;
    start2 = 1'b0;
    mode = 0;
    repeat (3) @(negedge clk);

    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_pass", pass, 0);
    check("rst_fail_cnt", fail_cnt, 0);
    check("rst_fail_addr", fail_addr, 0);
    check("rst_fail_elem", fail_elem, 0);
    check("rst_we", mem_write_read, 0);
    check("rst_addr", mem_address, 0);
    check("rst_wdata", mem_wdata, 0);
    rst = 1'b0;

    // Fault-free run with op-trace timing
    run_test(s, dc);
    check("clean_done_cycle", dc, s + 164);
    check("clean_busy_at_done", busy, 0);
    check("clean_pass", pass, 1);
    check("clean_fail_cnt", fail_cnt, 0);
    @(negedge clk);
    check("clean_pass_held", pass, 1);
    check("clean_done_one_cycle", done, 0);
    check("clean_busy_idle", tr_busy[s], 0);
    check("clean_busy_prep", tr_busy[s + 1], 1);
    check("clean_busy_drain", tr_busy[s + 163], 1);
    for (int i = 0; i < 16; i++) begin
      check("e0_we", tr_we[s + 2 + i], 1);
      check("e0_addr", tr_addr[s + 2 + i], i);
      check("e0_wdata_early", tr_wd[s + 1 + i], 8'h00);
    end
    check("op16_we", tr_we[s + 18], 0);
    check("op16_addr", tr_addr[s + 18], 0);
    check("op17_we", tr_we[s + 19], 1);
    check("op17_wdata_early", tr_wd[s + 18], 8'hFF);
    check("op79_we", tr_we[s + 81], 1);
    check("op79_addr", tr_addr[s + 81], 15);
    check("op79_wdata_early", tr_wd[s + 80], 8'h00);
    check("e3_first_we", tr_we[s + 82], 0);
    check("e3_first_addr", tr_addr[s + 82], 15);
    check("e3_w1_wdata_early", tr_wd[s + 82], 8'hFF);
    check("e3_last_addr", tr_addr[s + 113], 0);
    check("e4_first_addr", tr_addr[s + 114], 15);
    check("op159_we", tr_we[s + 161], 0);
    check("op159_addr", tr_addr[s + 161], 15);
    check("drain_we", tr_we[s + 162], 0);
    wr_cnt = 0;
    for (int k = 0; k < 160; k++) if (tr_we[s + 2 + k]) wr_cnt++;
    check("write_count", wr_cnt, 80);

    // Stuck-at 0 on address 5 bit 3
    mode = 1;
    run_test(s, dc);
    check("sa0_done_cycle", dc, s + 164);
    check("sa0_fail_cnt", fail_cnt, 2);
    check("sa0_fail_addr", fail_addr, 5);
    check("sa0_fail_elem", fail_elem, 2);
    check("sa0_pass", pass, 0);

    // Address 9 stores bit 1 inverted: every read of 9 in E1..E5 fails
    mode = 2;
    run_test(s, dc);
    check("cpl_fail_cnt", fail_cnt, 5);
    check("cpl_fail_addr", fail_addr, 9);
    check("cpl_fail_elem", fail_elem, 1);
    check("cpl_pass", pass, 0);

    // Reset mid-test
    mode = 0;
    @(negedge clk);
    start = 1'b1;
    s = cyc;
    @(negedge clk);
    start = 1'b0;
    repeat (49) @(negedge clk);
    check("abort_busy_before", busy, 1);
    rst = 1'b1;
    @(negedge clk);
    check("abort_busy", busy, 0);
    check("abort_done", done, 0);
    check("abort_pass", pass, 0);
    check("abort_fail_cnt", fail_cnt, 0);
    check("abort_we", mem_write_read, 0);
    check("abort_addr", mem_address, 0);
    check("abort_wdata", mem_wdata, 0);
    rst = 1'b0;
    @(negedge clk);
    d0 = done_cnt;
    repeat (200) @(negedge clk);
    check("abort_no_done", done_cnt, d0);
    run_test(s, dc);
    check("rerun_done_cycle", dc, s + 164);
    check("rerun_pass", pass, 1);
    check("rerun_fail_cnt", fail_cnt, 0);

    // Start held high on the all-failing instance with a 4-bit counter
    @(negedge clk);
    start2 = 1'b1;
    s = cyc;
    cap_cnt = '0; cap_addr = '0; cap_elem = '0; cap_pass = 1'b1; cap_done = 1'b0;
    cap_we = 1'b0; cap_a = 4'hF; cap_wd = 8'hFF;
    for (int i = 1; i < 200; i++) begin
      @(negedge clk);
      if (cyc == s + 2) begin
        cap_we = mem_write_read2;
        cap_a  = mem_address2;
        cap_wd = mem_wdata2;
      end
      if (cyc == s + 164) begin
        cap_cnt  = fail_cnt2;
        cap_addr = fail_addr2;
        cap_elem = fail_elem2;
        cap_pass = pass2;
        cap_done = done2;
      end
    end
    @(negedge clk);
    start2 = 1'b0;
    check("hold_single_done", done2_cnt, 1);
    check("hold_op0_we", cap_we, 1);
    check("hold_op0_addr", cap_a, 0);
    check("hold_op0_wdata", cap_wd, 8'h00);
    check("hold_done_at_164", cap_done, 1);
    check("sat_fail_cnt", cap_cnt, 15);
    check("sat_fail_addr", cap_addr, 0);
    check("sat_fail_elem", cap_elem, 1);
    check("sat_pass", cap_pass, 0);
    check("hold_busy_done", tr_busy2[s + 164], 0);
    check("hold_busy_idle", tr_busy2[s + 165], 0);
    check("hold_busy_restart", tr_busy2[s + 166], 1);
    n = 0;
    while (done2_cnt < 2 && n < 400) begin
      @(negedge clk);
      n++;
    end
    @(negedge clk);
    check("hold_second_done_cycle", last_done2, s + 329);
    check("hold_done_total", done2_cnt, 2);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
